// File: rtl/cci_mpf_shim_edge_wr_heap_alloc.sv
// Write-heap slot free list: FWFT circular FIFO of free indices
// plus a busy vector that catches double frees.
module cci_mpf_shim_edge_wr_heap_alloc #(
    parameter  int N_ENTRIES      = 64,
    parameter  int MIN_FREE_SLOTS = 2,
    localparam int IDX_W          = $clog2(N_ENTRIES),
    localparam int CNT_W          = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             alloc_rdy,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             alloc_en,
    input  logic             free_en,
    input  logic [IDX_W-1:0] free_idx,
    output logic [CNT_W-1:0] free_cnt,
    output logic             heap_almost_full,
    output logic             init_done,
    output logic             err_double_free,
    output logic             err_alloc_empty
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_fifo [N_ENTRIES];
    logic [IDX_W-1:0]     r_rd_ptr;
    logic [IDX_W-1:0]     r_wr_ptr;
    logic [IDX_W-1:0]     r_init_ctr;
    logic [N_ENTRIES-1:0] r_busy;
    logic [CNT_W-1:0]     r_free_cnt;
    logic                 r_almost_full;
    logic                 r_err_df;
    logic                 r_err_ae;

    logic                 w_run;
    logic                 w_rdy;
    logic [IDX_W-1:0]     w_head;
    logic                 w_alloc;
    logic                 w_free;
    logic                 w_init_last;
    logic                 w_run_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    assign w_run       = (r_state == S_RUN);
    assign w_rdy       = w_run && (r_free_cnt != '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_alloc     = alloc_en && w_rdy;
    assign w_free      = w_run && free_en && r_busy[free_idx];
    assign w_init_last = !w_run && (r_init_ctr == IDX_W'(N_ENTRIES - 1));
    assign w_run_nxt   = w_run || w_init_last;

    // Next free count; a simultaneous alloc and free cancel out
    always_comb begin
        w_cnt_nxt = r_free_cnt;
        if (!w_run) begin
            w_cnt_nxt = r_free_cnt + 1'b1;
        end else if (w_alloc && !w_free) begin
            w_cnt_nxt = r_free_cnt - 1'b1;
        end else if (w_free && !w_alloc) begin
            w_cnt_nxt = r_free_cnt + 1'b1;
        end
    end

    // Free-list storage: seeded with 0..N-1 in INIT, then recycled slots
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (!w_run) begin
                r_fifo[r_wr_ptr] <= r_init_ctr;
            end else if (w_free) begin
                r_fifo[r_wr_ptr] <= free_idx;
            end
        end
    end

    // Control FSM, pointers, busy tracking and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_INIT;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_init_ctr    <= '0;
            r_busy        <= '0;
            r_free_cnt    <= '0;
            r_almost_full <= 1'b1;
            r_err_df      <= 1'b0;
            r_err_ae      <= 1'b0;
        end else begin
            r_free_cnt    <= w_cnt_nxt;
            r_almost_full <= !w_run_nxt ||
                             (w_cnt_nxt <= CNT_W'(MIN_FREE_SLOTS));
            r_err_ae      <= alloc_en && !w_rdy;
            r_err_df      <= w_run && free_en && !r_busy[free_idx];
            unique case (r_state)
                S_INIT: begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_init_ctr <= r_init_ctr + 1'b1;
                    if (w_init_last) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_alloc) begin
                        r_rd_ptr       <= r_rd_ptr + 1'b1;
                        r_busy[w_head] <= 1'b1;
                    end
                    if (w_free) begin
                        r_wr_ptr         <= r_wr_ptr + 1'b1;
                        r_busy[free_idx] <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign alloc_rdy        = w_rdy;
    assign alloc_idx        = w_head;
    assign free_cnt         = r_free_cnt;
    assign heap_almost_full = r_almost_full;
    assign init_done        = w_run;
    assign err_double_free  = r_err_df;
    assign err_alloc_empty  = r_err_ae;

endmodule

// File: tb/tb_cci_mpf_shim_edge_wr_heap_alloc.sv
// Bench for the write-heap allocator: queue-based free-list model,
// per-cycle output compare, directed scenarios and random traffic.
module tb_cci_mpf_shim_edge_wr_heap_alloc;

    localparam int N   = 8;
    localparam int MIN = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       alloc_rdy;
    logic [2:0] alloc_idx;
    logic       alloc_en;
    logic       free_en;
    logic [2:0] free_idx;
    logic [3:0] free_cnt;
    logic       heap_almost_full;
    logic       init_done;
    logic       err_double_free;
    logic       err_alloc_empty;

    int total = 0;
    int bad   = 0;

    cci_mpf_shim_edge_wr_heap_alloc #(
        .N_ENTRIES      (N),
        .MIN_FREE_SLOTS (MIN)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alloc_rdy        (alloc_rdy),
        .alloc_idx        (alloc_idx),
        .alloc_en         (alloc_en),
        .free_en          (free_en),
        .free_idx         (free_idx),
        .free_cnt         (free_cnt),
        .heap_almost_full (heap_almost_full),
        .init_done        (init_done),
        .err_double_free  (err_double_free),
        .err_alloc_empty  (err_alloc_empty)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
        end
    endfunction

    // Behavioural model: free list as a queue of indices
    int m_q[$];
    bit m_busy[N];
    int m_init_left = N;
    bit m_err_df    = 1'b0;
    bit m_err_ae    = 1'b0;

    // Compare outputs mid-cycle, then advance the model with the
    // inputs that the next rising edge will sample
    always @(negedge clk) begin : cmp
        bit e_done;
        bit e_rdy;
        bit a_ok;
        bit f_ok;
        int fi;
        e_done = (m_init_left == 0);
        e_rdy  = e_done && (m_q.size() > 0);
        chk("init_done", int'(init_done), int'(e_done));
        chk("alloc_rdy", int'(alloc_rdy), int'(e_rdy));
        chk("free_cnt", int'(free_cnt), m_q.size());
        chk("almost_full", int'(heap_almost_full),
            int'(!e_done || m_q.size() <= MIN));
        chk("err_double_free", int'(err_double_free), int'(m_err_df));
        chk("err_alloc_empty", int'(err_alloc_empty), int'(m_err_ae));
        if (e_rdy) chk("alloc_idx", int'(alloc_idx), m_q[0]);

        if (!reset_n) begin
            m_q.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_init_left = N;
            m_err_df    = 1'b0;
            m_err_ae    = 1'b0;
        end else if (m_init_left > 0) begin
            m_err_ae = alloc_en;
            m_err_df = 1'b0;
            m_q.push_back(N - m_init_left);
            m_init_left--;
        end else begin
            fi       = int'(free_idx);
            a_ok     = alloc_en && (m_q.size() > 0);
            f_ok     = free_en && m_busy[fi];
            m_err_ae = alloc_en && (m_q.size() == 0);
            m_err_df = free_en && !m_busy[fi];
            if (a_ok) m_busy[m_q.pop_front()] = 1'b1;
            if (f_ok) begin
                m_busy[fi] = 1'b0;
                m_q.push_back(fi);
            end
        end
    end

    task automatic step(input bit r, input bit a, input bit f, input int fi);
        reset_n  = r;
        alloc_en = a;
        free_en  = f;
        free_idx = fi[2:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        alloc_en = 1'b0;
        free_en  = 1'b0;
        free_idx = '0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0);
        chk("rst_almost_full", int'(heap_almost_full), 1);
        chk("rst_free_cnt", int'(free_cnt), 0);

        // Initialisation takes N cycles
        repeat (N) step(1, 0, 0, 0);
        chk("init_done_lit", int'(init_done), 1);
        chk("init_cnt_lit", int'(free_cnt), 8);
        chk("init_idx_lit", int'(alloc_idx), 0);
        chk("init_af_lit", int'(heap_almost_full), 0);

        // Drain in order
        for (int i = 0; i < N; i++) begin
            chk("drain_idx_lit", int'(alloc_idx), i);
            step(1, 1, 0, 0);
            if (i == 2) chk("cnt_after3_lit", int'(free_cnt), 5);
            if (i == 4) chk("af_after5_lit", int'(heap_almost_full), 0);
            if (i == 5) chk("af_after6_lit", int'(heap_almost_full), 1);
        end
        chk("empty_rdy_lit", int'(alloc_rdy), 0);
        step(1, 1, 0, 0);
        chk("err_ae_lit", int'(err_alloc_empty), 1);
        step(1, 0, 0, 0);
        chk("err_ae_clr_lit", int'(err_alloc_empty), 0);

        // Recycle into empty list
        step(1, 0, 1, 5);
        chk("recycle_rdy_lit", int'(alloc_rdy), 1);
        chk("recycle_idx_lit", int'(alloc_idx), 5);
        chk("recycle_cnt_lit", int'(free_cnt), 1);

        // Double free
        step(1, 0, 1, 0);
        chk("free0_cnt_lit", int'(free_cnt), 2);
        step(1, 0, 1, 0);
        chk("dfree_lit", int'(err_double_free), 1);
        chk("dfree_cnt_lit", int'(free_cnt), 2);
        step(1, 0, 0, 0);
        chk("dfree_clr_lit", int'(err_double_free), 0);

        // Simultaneous alloc (head 5) and free of busy slot 1
        step(1, 1, 1, 1);
        chk("simul_cnt_lit", int'(free_cnt), 2);
        chk("simul_head_lit", int'(alloc_idx), 0);
        step(1, 1, 0, 0);
        chk("simul_tail_lit", int'(alloc_idx), 1);
        chk("simul_cnt2_lit", int'(free_cnt), 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, N - 1)));
        end

        // Reset after partial allocation forgets everything
        step(0, 0, 0, 0);
        repeat (N) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("pre_rst_cnt_lit", int'(free_cnt), 4);
        step(0, 0, 0, 0);
        repeat (N) step(1, 0, 0, 0);
        chk("rerst_cnt_lit", int'(free_cnt), 8);
        chk("rerst_idx_lit", int'(alloc_idx), 0);
        step(1, 0, 1, 2);
        chk("rerst_dfree_lit", int'(err_double_free), 1);
        step(1, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
